// File: rtl/cpu_ctl.sv
// Owns the 6502 /RES and RDY pins: stretches reset pulses and lands RDY drops on read cycles.
// Optional build macro CPU_CTL_SYNC_HALT_EN restricts RDY drops to opcode-fetch cycles.
module cpu_ctl #(
  parameter int RESET_CYCLES = 4
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       wr_strobe_i,
  input  logic [1:0] wr_data_i,
  input  logic       cpu_en_i,
  input  logic       cpu_rw_n_i,
  input  logic       cpu_sync_i,
  output logic       cpu_res_n_o,
  output logic       cpu_rdy_o,
  output logic [1:0] status_o,
  output logic       busy_o
);

  localparam logic [7:0] CNT_LOAD = 8'(RESET_CYCLES);

  typedef enum logic [1:0] {
    RST_HOLD    = 2'd0,
    RST_STRETCH = 2'd1,
    RST_RUN     = 2'd2
  } rst_state_e;

  typedef enum logic [1:0] {
    RDY_OFF   = 2'd0,
    RDY_ON    = 2'd1,
    RDY_DRAIN = 2'd2
  } rdy_state_e;

  function automatic logic [7:0] sat_dec(input logic [7:0] v, input logic en);
    return (en && (v != 8'd0)) ? (v - 8'd1) : v;
  endfunction

  logic       req_reset_q, req_reset_d;
  logic       req_ready_q, req_ready_d;
  rst_state_e rst_state_q, rst_state_d;
  rdy_state_e rdy_state_q, rdy_state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       res_n_q, res_n_d;
  logic       rdy_q, rdy_d;
  logic       drain_exit;

`ifdef CPU_CTL_SYNC_HALT_EN
  assign drain_exit = cpu_en_i & cpu_rw_n_i & cpu_sync_i;
`else
  logic unused_sync;
  assign unused_sync = cpu_sync_i;
  assign drain_exit  = cpu_en_i & cpu_rw_n_i;
`endif

  // request latch: last write wins, FSMs see it from the following cycle
  always_comb begin
    req_reset_d = req_reset_q;
    req_ready_d = req_ready_q;
    if (wr_strobe_i) begin
      req_reset_d = wr_data_i[0];
      req_ready_d = wr_data_i[1];
    end
  end

  // reset FSM: the release decision uses the post-decrement count so /RES rises on the last pulse
  always_comb begin
    rst_state_d = rst_state_q;
    cnt_d       = cnt_q;
    res_n_d     = res_n_q;
    unique case (rst_state_q)
      RST_RUN: begin
        if (req_reset_q) begin
          rst_state_d = RST_HOLD;
          cnt_d       = CNT_LOAD;
          res_n_d     = 1'b0;
        end
      end
      RST_HOLD: begin
        cnt_d = sat_dec(cnt_q, cpu_en_i);
        if (cnt_d == 8'd0) begin
          if (req_reset_q) begin
            rst_state_d = RST_STRETCH;
          end else begin
            rst_state_d = RST_RUN;
            res_n_d     = 1'b1;
          end
        end
      end
      RST_STRETCH: begin
        if (!req_reset_q) begin
          rst_state_d = RST_RUN;
          res_n_d     = 1'b1;
        end
      end
      default: begin
        rst_state_d = RST_HOLD;
        cnt_d       = CNT_LOAD;
        res_n_d     = 1'b0;
      end
    endcase
  end

  // ready FSM: RDY stays high through DRAIN; a returning ready request wins to avoid a glitch
  always_comb begin
    rdy_state_d = rdy_state_q;
    rdy_d       = rdy_q;
    unique case (rdy_state_q)
      RDY_OFF: begin
        if (req_ready_q) begin
          rdy_state_d = RDY_ON;
          rdy_d       = 1'b1;
        end
      end
      RDY_ON: begin
        if (!req_ready_q) begin
          rdy_state_d = RDY_DRAIN;
        end
      end
      RDY_DRAIN: begin
        if (req_ready_q) begin
          rdy_state_d = RDY_ON;
        end else if ((rst_state_q != RST_RUN) || drain_exit) begin
          rdy_state_d = RDY_OFF;
          rdy_d       = 1'b0;
        end
      end
      default: begin
        rdy_state_d = RDY_OFF;
        rdy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      req_reset_q <= 1'b1;
      req_ready_q <= 1'b0;
      rst_state_q <= RST_HOLD;
      rdy_state_q <= RDY_OFF;
      cnt_q       <= CNT_LOAD;
      res_n_q     <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      req_reset_q <= req_reset_d;
      req_ready_q <= req_ready_d;
      rst_state_q <= rst_state_d;
      rdy_state_q <= rdy_state_d;
      cnt_q       <= cnt_d;
      res_n_q     <= res_n_d;
      rdy_q       <= rdy_d;
    end
  end

  assign cpu_res_n_o = res_n_q;
  assign cpu_rdy_o   = rdy_q;
  assign status_o    = {rdy_q, ~res_n_q};
  assign busy_o      = (rst_state_q == RST_HOLD) | (rdy_state_q == RDY_DRAIN) |
                       (res_n_q == req_reset_q) | (rdy_q != req_ready_q);

endmodule
